// File: rtl/approx_prod_accum.sv
// Purpose : sums a stream of LEN approximate 8x8 products into one dot-product result.
// Latency : out_valid rises one cycle after the last accepted beat (LEN+1 cycles from start).
// Backpr. : in_ready only in ACC; result held in DONE until out_ready; beats outside ACC dropped.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, len           job request and product count (sampled only in IDLE)
//   in_valid/in_ready    input beat handshake carrying in_a, in_b, in_prod
//   out_valid/out_ready  result handshake carrying out_sum, out_ovf
//   busy                 high whenever the FSM is not in IDLE
//   err_sum              accumulated |a*b - prod|, only when APPROX_ERR_MON_EN is defined
//
// Optional feature macro: APPROX_ERR_MON_EN (adds exact multiplier and err_sum port).
module approx_prod_accum #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [15:0]      in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
`ifdef APPROX_ERR_MON_EN
    ,
    output logic [ACC_W-1:0] err_sum
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             beat;
    logic [ACC_W:0]   acc_ext;

    assign beat = in_valid && in_ready;

    // One extra bit captures the carry out of the accumulator MSB.
    assign acc_ext = {1'b0, acc} + (ACC_W+1)'(in_prod);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LEN_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            cnt <= len;
            acc <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            cnt <= cnt - LEN_W'(1);
            acc <= acc_ext[ACC_W-1:0];
            // Sticky: any wrap during the job keeps the flag set.
            ovf <= ovf | acc_ext[ACC_W];
        end
    end

    // acc only changes in IDLE (on start) or ACC, so it is stable through DONE
    // and keeps the last result after the handshake.
    assign out_sum = acc;
    assign out_ovf = ovf;

`ifdef APPROX_ERR_MON_EN
    logic [15:0]      exact;
    logic [15:0]      err_diff;
    logic [ACC_W-1:0] err_acc;

    assign exact    = {8'd0, in_a} * {8'd0, in_b};
    assign err_diff = (exact >= in_prod) ? (exact - in_prod) : (in_prod - exact);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_acc <= '0;
        end else if (state == IDLE && start) begin
            err_acc <= '0;
        end else if (beat) begin
            err_acc <= err_acc + ACC_W'(err_diff);
        end
    end

    assign err_sum = err_acc;
`else
    // Operands only feed the error monitor; without it they are intentionally unused.
    logic unused_operands;
    assign unused_operands = ^{in_a, in_b};
`endif

endmodule

// File: tb/tb_approx_prod_accum.sv
// Purpose : self-checking bench for approx_prod_accum (default ACC_W=24 and a 17-bit instance).
// Latency : checks out_valid timing one cycle after the last accepted beat.
// Backpr. : exercises input stalls, held results under out_ready low, and dropped beats.
module tb_approx_prod_accum;

    logic        clk;
    logic        rst_n;

    // Instance 0: default parameters
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [15:0] in_prod;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_sum;
    logic        out_ovf;
    logic        busy;

    // Instance 1: ACC_W = 17 for overflow checking
    logic        s_start;
    logic [7:0]  s_len;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_a;
    logic [7:0]  s_in_b;
    logic [15:0] s_in_prod;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [16:0] s_out_sum;
    logic        s_out_ovf;
    logic        s_busy;

`ifdef APPROX_ERR_MON_EN
    logic [23:0] err_sum;
    logic [16:0] s_err_sum;
`endif

    int total;
    int bad;

    approx_prod_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
`ifdef APPROX_ERR_MON_EN
        ,
        .err_sum   (err_sum)
`endif
    );

    approx_prod_accum #(.ACC_W(17), .LEN_W(8)) dut17 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .len       (s_len),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_a      (s_in_a),
        .in_b      (s_in_b),
        .in_prod   (s_in_prod),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sum   (s_out_sum),
        .out_ovf   (s_out_ovf),
        .busy      (s_busy)
`ifdef APPROX_ERR_MON_EN
        ,
        .err_sum   (s_err_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  vlen;
        logic [15:0] prod [4];
        logic [23:0] exp_sum;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All driving happens just after a falling edge; DUT samples on the next rising edge.
    task automatic start_job(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        len   = 8'd0;
    endtask

    task automatic send(input logic [15:0] p, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_prod  = p;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_prod  = 16'd0;
        in_a     = 8'd0;
        in_b     = 8'd0;
    endtask

    task automatic finish_job;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic s_send(input logic [15:0] p);
        s_in_valid = 1'b1;
        s_in_prod  = p;
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_prod  = 16'd0;
    endtask

    initial begin
        logic [23:0] held;
        total = 0;
        bad   = 0;

        vecs[0] = '{vlen: 8'd3, prod: '{16'd100, 16'd200, 16'd300, 16'd0},
                    exp_sum: 24'd600, exp_ovf: 1'b0};
        vecs[1] = '{vlen: 8'd1, prod: '{16'hFFFF, 16'd0, 16'd0, 16'd0},
                    exp_sum: 24'h00FFFF, exp_ovf: 1'b0};
        vecs[2] = '{vlen: 8'd4, prod: '{16'd1, 16'd2, 16'd3, 16'd4},
                    exp_sum: 24'd10, exp_ovf: 1'b0};
        vecs[3] = '{vlen: 8'd2, prod: '{16'h8000, 16'h8000, 16'd0, 16'd0},
                    exp_sum: 24'h010000, exp_ovf: 1'b0};

        rst_n = 1'b0;
        start = 1'b0; len = 8'd0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0;
        in_prod = 16'd0; out_ready = 1'b0;
        s_start = 1'b0; s_len = 8'd0; s_in_valid = 1'b0; s_in_a = 8'd0; s_in_b = 8'd0;
        s_in_prod = 16'd0; s_out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset out_sum", out_sum, 0);
        check("reset out_ovf", out_ovf, 0);
`ifdef APPROX_ERR_MON_EN
        check("reset err_sum", err_sum, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven back-to-back jobs without stalls
        for (int v = 0; v < 4; v++) begin
            check($sformatf("v%0d idle in_ready", v), in_ready, 0);
            start_job(vecs[v].vlen);
            check($sformatf("v%0d busy", v), busy, 1);
            for (int k = 0; k < int'(vecs[v].vlen); k++) begin
                check($sformatf("v%0d b%0d in_ready", v, k), in_ready, 1);
                check($sformatf("v%0d b%0d out_valid early", v, k), out_valid, 0);
                send(vecs[v].prod[k], 8'd0, 8'd0);
            end
            check($sformatf("v%0d out_valid", v), out_valid, 1);
            check($sformatf("v%0d in_ready done", v), in_ready, 0);
            check($sformatf("v%0d out_sum", v), out_sum, vecs[v].exp_sum);
            check($sformatf("v%0d out_ovf", v), out_ovf, vecs[v].exp_ovf);
            finish_job();
            check($sformatf("v%0d back idle", v), busy, 0);
            check($sformatf("v%0d sum kept", v), out_sum, vecs[v].exp_sum);
        end

        // len=2 with 5-cycle input gaps and 4 cycles of out_ready low
        start_job(8'd2);
        repeat (5) @(negedge clk);
        check("stall acc hold ready", in_ready, 1);
        send(16'd1000, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("gap%0d out_valid", i), out_valid, 0);
        end
        send(16'd234, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold%0d out_valid", i), out_valid, 1);
            check($sformatf("hold%0d out_sum", i), out_sum, 1234);
            @(negedge clk);
        end
        finish_job();
        check("stall job idle out_valid", out_valid, 0);
        check("stall job idle busy", busy, 0);
        @(negedge clk);
        check("stall job single result", out_valid, 0);
        check("stall job sum kept", out_sum, 1234);

        // len=0: straight to DONE with a cleared sum; offered beats are not accepted
        in_valid = 1'b1;
        in_prod  = 16'd77;
        check("len0 idle in_ready", in_ready, 0);
        start_job(8'd0);
        check("len0 out_valid", out_valid, 1);
        check("len0 out_sum", out_sum, 0);
        check("len0 out_ovf", out_ovf, 0);
        check("len0 in_ready", in_ready, 0);
        @(negedge clk);
        check("len0 in_ready hold", in_ready, 0);
        check("len0 sum hold", out_sum, 0);
        finish_job();
        check("len0 idle", busy, 0);
        in_valid = 1'b0;
        in_prod  = 16'd0;

        // Reset after 2 of 4 beats discards the job
        start_job(8'd4);
        send(16'd40, 8'd0, 8'd0);
        send(16'd50, 8'd0, 8'd0);
        check("pre-reset partial sum", out_sum, 90);
        rst_n = 1'b0;
        #1;
        check("midreset in_ready", in_ready, 0);
        check("midreset busy", busy, 0);
        check("midreset out_valid", out_valid, 0);
        check("midreset out_sum", out_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_job(8'd1);
        send(16'd7, 8'd0, 8'd0);
        check("post-reset out_valid", out_valid, 1);
        check("post-reset out_sum", out_sum, 7);
        finish_job();

        // ACC_W=17 overflow: 3 * 0xFFFF = 0x2FFFD -> 0x0FFFD with carry
        s_start = 1'b1;
        s_len   = 8'd3;
        @(negedge clk);
        s_start = 1'b0;
        s_len   = 8'd0;
        for (int k = 0; k < 3; k++) s_send(16'hFFFF);
        check("w17 out_valid", s_out_valid, 1);
        check("w17 out_sum", s_out_sum, 32'h0FFFD);
        check("w17 out_ovf", s_out_ovf, 1);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        check("w17 ovf sticky after handshake", s_out_ovf, 1);
        s_start = 1'b1;
        s_len   = 8'd1;
        @(negedge clk);
        s_start = 1'b0;
        s_len   = 8'd0;
        check("w17 ovf cleared on start", s_out_ovf, 0);
        s_send(16'd5);
        check("w17 next sum", s_out_sum, 5);
        check("w17 next ovf", s_out_ovf, 0);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;

`ifdef APPROX_ERR_MON_EN
        // 15*15=225 vs 224 -> err 1; 3*4=12 vs 12 -> err 0; start during ACC ignored
        start_job(8'd2);
        check("err cleared", err_sum, 0);
        send(16'd224, 8'd15, 8'd15);
        start = 1'b1;
        len   = 8'd1;
        @(negedge clk);
        start = 1'b0;
        len   = 8'd0;
        check("err start ignored", out_valid, 0);
        check("err still acc", in_ready, 1);
        send(16'd12, 8'd3, 8'd4);
        check("err out_valid", out_valid, 1);
        check("err err_sum", err_sum, 1);
        check("err out_sum", out_sum, 236);
        finish_job();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
